usb_stream_arbiter: RTL and testbench
=====================================

USB_STREAM_ARBITER -- requirements
Module: usb_stream_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving the byte width of all tdata ports.
REQ-002 SHALL have parameter DELIM, default 8'h00, giving the COBS packet delimiter value.
REQ-003 SHALL have parameter MAX_PKT_BYTES, default 512, giving the overlong-packet watchdog limit in bytes.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 src_en  input  2  per-source enable; bit0 = source 0 (HSADC COBS stream), bit1 = source 1 (XADC COBS stream).
REQ-007 s0_tdata / s0_tvalid / s0_tready  in / in / out  DATA_WIDTH / 1 / 1  AXIS sink, source 0.
REQ-008 s1_tdata / s1_tvalid / s1_tready  in / in / out  DATA_WIDTH / 1 / 1  AXIS sink, source 1.
REQ-009 m_tdata / m_tvalid / m_tready  out / out / in  DATA_WIDTH / 1 / 1  AXIS source toward the ft232h sys_axis sink.
REQ-010 grant  output  2  one-hot current owner; 2'b00 when idle.
REQ-011 err_overlong  output  1  one-cycle pulse when the watchdog force-releases a grant.
REQ-012 pkt_count0, pkt_count1  output  32 each  completed-packet counters (see Configuration).

Function
REQ-013 SHALL implement FSM states IDLE, GRANT0, GRANT1.
REQ-014 IDLE: the block SHALL accept nothing: s0_tready=0, s1_tready=0, m_tvalid=0.
REQ-015 A source is eligible in IDLE when its tvalid=1 and its src_en bit is 1; src_en SHALL be sampled only in IDLE.
REQ-016 With one source eligible, IDLE SHALL move to that source's GRANT state on the next clk edge.
REQ-017 With both eligible, IDLE SHALL grant the source not served last (round-robin); after reset, source 0 wins the first tie.
REQ-018 In GRANTn: m_tdata=sn_tdata, m_tvalid=sn_tvalid, sn_tready=m_tready, other source's tready=0; this path SHALL be combinational, zero added latency.
REQ-019 A byte SHALL be transferred only on a cycle with m_tvalid & m_tready.
REQ-020 A transferred byte equal to DELIM SHALL end the packet: FSM returns to IDLE next cycle, and the last-served register updates to n.
REQ-021 Arbitration gap SHALL be exactly one idle cycle between packets (the IDLE decision cycle).
REQ-022 A per-grant byte counter SHALL count transfers, cleared on entry to GRANT.
REQ-023 If the counter reaches MAX_PKT_BYTES transfers without DELIM, the FSM SHALL return to IDLE, pulse err_overlong for one cycle, and update last-served.
REQ-024 A DELIM transfer on the same cycle the limit is reached SHALL count as a normal packet end; err_overlong stays 0.
REQ-025 Deasserting src_en bit n during GRANTn SHALL NOT truncate the packet; the grant holds until DELIM or watchdog.
REQ-026 sn_tvalid dropping mid-packet SHALL hold the grant (m_tvalid follows to 0); no timeout other than the byte watchdog.
REQ-027 grant SHALL be a registered decode of the FSM state.

Reset
REQ-028 rst_n=0 SHALL asynchronously force: state IDLE, grant=2'b00, last-served=source 1 (so source 0 wins the first tie), byte counter 0, err_overlong 0, pkt_count0/1 0.
REQ-029 Reset asserted mid-packet SHALL abandon the packet; after release the next grant starts fresh in IDLE.
REQ-030 Deassertion SHALL be synchronised to clk with a two-flop synchroniser before use.

Configuration
REQ-031 Macro USB_ARB_STATS_EN defined: pkt_count0/1 SHALL increment by 1 per DELIM transfer from the respective source and wrap 32'hFFFFFFFF to 0.
REQ-032 Macro USB_ARB_STATS_EN undefined: ports pkt_count0/1 SHALL remain and be tied to 0, with no counter flops.

Verification
REQ-033 Only s0 valid, src_en=2'b11, packet 03 11 22 00, m_tready=1 -> grant=01 one cycle after s0_tvalid, four bytes out in order, IDLE after 00.
REQ-034 Both valid from reset, each with 3-byte packet ending 00 -> s0 packet first, 1 idle cycle, then s1 packet, no interleave.
REQ-035 m_tready toggled 1/0 during GRANT1 -> s1_tready mirrors m_tready, s0_tready=0 throughout, byte order preserved.
REQ-036 MAX_PKT_BYTES=4, s0 sends 01 02 03 04 05 without 00 -> err_overlong pulses after 4th transfer, 05 is not transferred, grant released.
REQ-037 src_en=2'b10 with both valid -> only s1 is granted; src_en cleared mid-s1 packet -> packet completes to 00.
REQ-038 rst_n low mid-packet, with USB_ARB_STATS_EN -> grant=00, counters 0 immediately; after two packets from s1, pkt_count1=2.

Source files
------------

// File: rtl/usb_stream_arbiter_if.sv
// AXI-Stream byte channel used by the USB stream arbiter.
// master drives tdata/tvalid, slave drives tready.
interface usb_stream_arbiter_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (
        output tdata,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/usb_stream_arbiter.sv
// Packet-level round-robin arbiter merging two COBS streams toward ft232h.
// Optional macro USB_ARB_STATS_EN adds per-source completed-packet counters.
module usb_stream_arbiter #(
    parameter int                    DATA_WIDTH    = 8,
    parameter logic [DATA_WIDTH-1:0] DELIM         = '0,
    parameter int                    MAX_PKT_BYTES = 512
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           src_en,
    usb_stream_arbiter_if.slave  s0,
    usb_stream_arbiter_if.slave  s1,
    usb_stream_arbiter_if.master m,
    output logic [1:0]           grant,
    output logic                 err_overlong,
    output logic [31:0]          pkt_count0,
    output logic [31:0]          pkt_count1
);

    localparam int CW = $clog2(MAX_PKT_BYTES + 1);
    localparam logic [CW-1:0] LIM = CW'(MAX_PKT_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    logic [1:0]    r_rst_sync;
    logic          w_rst_n;
    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic          r_last;
    logic          r_err;
    logic [1:0]    r_grant;
    logic          w_e0;
    logic          w_e1;
    logic          w_xfer;
    logic          w_end;
    logic          w_wd;
    logic          w_src;

    // Release of reset is re-timed to clk; assertion stays asynchronous.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    assign w_e0 = s0.tvalid & src_en[0];
    assign w_e1 = s1.tvalid & src_en[1];

    // Next-state decision plus the combinational data path of the owner.
    always_comb begin
        w_state_nxt = r_state;
        m.tdata     = '0;
        m.tvalid    = 1'b0;
        s0.tready   = 1'b0;
        s1.tready   = 1'b0;
        w_xfer      = 1'b0;
        w_end       = 1'b0;
        w_wd        = 1'b0;
        w_src       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_e0 && w_e1) begin
                    w_state_nxt = r_last ? GRANT0 : GRANT1;
                end else if (w_e0) begin
                    w_state_nxt = GRANT0;
                end else if (w_e1) begin
                    w_state_nxt = GRANT1;
                end
            end
            GRANT0: begin
                m.tdata   = s0.tdata;
                m.tvalid  = s0.tvalid;
                s0.tready = m.tready;
                w_xfer    = s0.tvalid & m.tready;
                w_src     = 1'b0;
            end
            GRANT1: begin
                m.tdata   = s1.tdata;
                m.tvalid  = s1.tvalid;
                s1.tready = m.tready;
                w_xfer    = s1.tvalid & m.tready;
                w_src     = 1'b1;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        if (w_xfer) begin
            if (m.tdata == DELIM) begin
                w_end = 1'b1;
            end else if (r_cnt == LIM) begin
                w_wd = 1'b1;
            end
        end
        if (w_end || w_wd) begin
            w_state_nxt = IDLE;
        end
    end

    // State register with grant decoded from the next state.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= IDLE;
            r_grant <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= {w_state_nxt == GRANT1, w_state_nxt == GRANT0};
        end
    end

    // Per-grant transfer counter, restarted while idle.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_cnt <= '0;
        end else if (r_state == IDLE) begin
            r_cnt <= '0;
        end else if (w_xfer) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Last-served source and the one-cycle watchdog pulse.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_last <= 1'b1;
            r_err  <= 1'b0;
        end else begin
            r_err <= w_wd;
            if (w_end || w_wd) begin
                r_last <= w_src;
            end
        end
    end

    assign grant        = r_grant;
    assign err_overlong = r_err;

`ifdef USB_ARB_STATS_EN
    logic [31:0] r_pkt0;
    logic [31:0] r_pkt1;

    // Completed packets per source; wraps naturally at 32 bits.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_pkt0 <= '0;
            r_pkt1 <= '0;
        end else if (w_end) begin
            if (w_src) begin
                r_pkt1 <= r_pkt1 + 32'd1;
            end else begin
                r_pkt0 <= r_pkt0 + 32'd1;
            end
        end
    end

    assign pkt_count0 = r_pkt0;
    assign pkt_count1 = r_pkt1;
`else
    assign pkt_count0 = 32'd0;
    assign pkt_count1 = 32'd0;
`endif

endmodule

// File: tb/tb_usb_stream_arbiter.sv
// Directed vector bench for usb_stream_arbiter (MAX_PKT_BYTES = 4).
// Each table row is one clock cycle: inputs and expected outputs.
module tb_usb_stream_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  src_en = 2'b00;
    logic [1:0]  grant;
    logic        err_overlong;
    logic [31:0] pkt_count0;
    logic [31:0] pkt_count1;

    int errors = 0;
    int checks = 0;

`ifdef USB_ARB_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    usb_stream_arbiter_if #(.DATA_WIDTH(8)) s0_if ();
    usb_stream_arbiter_if #(.DATA_WIDTH(8)) s1_if ();
    usb_stream_arbiter_if #(.DATA_WIDTH(8)) m_if ();

    usb_stream_arbiter #(
        .DATA_WIDTH   (8),
        .DELIM        (8'h00),
        .MAX_PKT_BYTES(4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .src_en      (src_en),
        .s0          (s0_if),
        .s1          (s1_if),
        .m           (m_if),
        .grant       (grant),
        .err_overlong(err_overlong),
        .pkt_count0  (pkt_count0),
        .pkt_count1  (pkt_count1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] en;
        logic       s0v;
        logic [7:0] s0d;
        logic       s1v;
        logic [7:0] s1d;
        logic       rdy;
        logic [1:0] g;
        logic       mv;
        logic [7:0] md;
        logic       s0r;
        logic       s1r;
        logic       err;
    } vec_t;

    vec_t tv[$];

    function automatic void v(
        input logic [1:0] en, input logic s0v, input logic [7:0] s0d,
        input logic s1v, input logic [7:0] s1d, input logic rdy,
        input logic [1:0] g, input logic mv, input logic [7:0] md,
        input logic s0r, input logic s1r, input logic err);
        vec_t r;
        r.en = en; r.s0v = s0v; r.s0d = s0d; r.s1v = s1v; r.s1d = s1d;
        r.rdy = rdy; r.g = g; r.mv = mv; r.md = md;
        r.s0r = s0r; r.s1r = s1r; r.err = err;
        tv.push_back(r);
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [13:0] obs();
        return {grant, m_if.tvalid, m_if.tdata, s0_if.tready,
                s1_if.tready, err_overlong};
    endfunction

    task automatic drive(input logic [1:0] en, input logic s0v,
                         input logic [7:0] s0d, input logic s1v,
                         input logic [7:0] s1d, input logic rdy);
        src_en       = en;
        s0_if.tvalid = s0v;
        s0_if.tdata  = s0d;
        s1_if.tvalid = s1v;
        s1_if.tdata  = s1d;
        m_if.tready  = rdy;
    endtask

    initial begin
        logic [13:0] exp;
        drive(2'b00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

        // Both sources, 3-byte packets from reset: s0 wins, gap, then s1.
        v(2'b11, 1, 8'hA1, 1, 8'hB1, 1, 2'b00, 0, 8'h00, 0, 0, 0);
        v(2'b11, 1, 8'hA1, 1, 8'hB1, 1, 2'b01, 1, 8'hA1, 1, 0, 0);
        v(2'b11, 1, 8'hA2, 1, 8'hB1, 1, 2'b01, 1, 8'hA2, 1, 0, 0);
        v(2'b11, 1, 8'h00, 1, 8'hB1, 1, 2'b01, 1, 8'h00, 1, 0, 0);
        v(2'b11, 1, 8'hC1, 1, 8'hB1, 1, 2'b00, 0, 8'h00, 0, 0, 0);
        v(2'b11, 1, 8'hC1, 1, 8'hB1, 1, 2'b10, 1, 8'hB1, 0, 1, 0);
        v(2'b11, 1, 8'hC1, 1, 8'hB2, 1, 2'b10, 1, 8'hB2, 0, 1, 0);
        v(2'b11, 1, 8'hC1, 1, 8'h00, 1, 2'b10, 1, 8'h00, 0, 1, 0);
        v(2'b11, 0, 8'h00, 0, 8'h00, 1, 2'b00, 0, 8'h00, 0, 0, 0);
        // Only s0: 03 11 22 00, DELIM lands exactly on the byte limit.
        v(2'b11, 1, 8'h03, 0, 8'h00, 1, 2'b00, 0, 8'h00, 0, 0, 0);
        v(2'b11, 1, 8'h03, 0, 8'h00, 1, 2'b01, 1, 8'h03, 1, 0, 0);
        v(2'b11, 1, 8'h11, 0, 8'h00, 1, 2'b01, 1, 8'h11, 1, 0, 0);
        v(2'b11, 1, 8'h22, 0, 8'h00, 1, 2'b01, 1, 8'h22, 1, 0, 0);
        v(2'b11, 1, 8'h00, 0, 8'h00, 1, 2'b01, 1, 8'h00, 1, 0, 0);
        v(2'b11, 0, 8'h00, 0, 8'h00, 1, 2'b00, 0, 8'h00, 0, 0, 0);
        // s1 with m_tready toggling; s0 waiting is held off.
        v(2'b11, 0, 8'h00, 1, 8'h31, 1, 2'b00, 0, 8'h00, 0, 0, 0);
        v(2'b11, 0, 8'h00, 1, 8'h31, 1, 2'b10, 1, 8'h31, 0, 1, 0);
        v(2'b11, 0, 8'h00, 1, 8'h32, 0, 2'b10, 1, 8'h32, 0, 0, 0);
        v(2'b11, 1, 8'hEE, 1, 8'h32, 1, 2'b10, 1, 8'h32, 0, 1, 0);
        v(2'b11, 1, 8'hEE, 1, 8'h00, 0, 2'b10, 1, 8'h00, 0, 0, 0);
        v(2'b11, 1, 8'hEE, 1, 8'h00, 1, 2'b10, 1, 8'h00, 0, 1, 0);
        v(2'b11, 0, 8'h00, 0, 8'h00, 1, 2'b00, 0, 8'h00, 0, 0, 0);
        // Watchdog: 01 02 03 04 05 with no DELIM.
        v(2'b11, 1, 8'h01, 0, 8'h00, 1, 2'b00, 0, 8'h00, 0, 0, 0);
        v(2'b11, 1, 8'h01, 0, 8'h00, 1, 2'b01, 1, 8'h01, 1, 0, 0);
        v(2'b11, 1, 8'h02, 0, 8'h00, 1, 2'b01, 1, 8'h02, 1, 0, 0);
        v(2'b11, 1, 8'h03, 0, 8'h00, 1, 2'b01, 1, 8'h03, 1, 0, 0);
        v(2'b11, 1, 8'h04, 0, 8'h00, 1, 2'b01, 1, 8'h04, 1, 0, 0);
        v(2'b00, 1, 8'h05, 0, 8'h00, 1, 2'b00, 0, 8'h00, 0, 0, 1);
        v(2'b11, 0, 8'h00, 0, 8'h00, 1, 2'b00, 0, 8'h00, 0, 0, 0);
        // src_en=10 grants s1 only; clearing it mid-packet does not cut it.
        v(2'b10, 1, 8'h51, 1, 8'h61, 1, 2'b00, 0, 8'h00, 0, 0, 0);
        v(2'b00, 1, 8'h51, 1, 8'h61, 1, 2'b10, 1, 8'h61, 0, 1, 0);
        v(2'b00, 1, 8'h51, 1, 8'h62, 1, 2'b10, 1, 8'h62, 0, 1, 0);
        v(2'b00, 1, 8'h51, 1, 8'h00, 1, 2'b10, 1, 8'h00, 0, 1, 0);
        v(2'b00, 1, 8'h51, 1, 8'h71, 1, 2'b00, 0, 8'h00, 0, 0, 0);
        v(2'b00, 0, 8'h00, 0, 8'h00, 1, 2'b00, 0, 8'h00, 0, 0, 0);
        // s0 tvalid gap mid-packet holds the grant.
        v(2'b01, 1, 8'h71, 0, 8'h00, 1, 2'b00, 0, 8'h00, 0, 0, 0);
        v(2'b01, 1, 8'h71, 0, 8'h00, 1, 2'b01, 1, 8'h71, 1, 0, 0);
        v(2'b01, 0, 8'h72, 0, 8'h00, 1, 2'b01, 0, 8'h72, 1, 0, 0);
        v(2'b01, 1, 8'h00, 0, 8'h00, 1, 2'b01, 1, 8'h00, 1, 0, 0);
        v(2'b01, 0, 8'h00, 0, 8'h00, 1, 2'b00, 0, 8'h00, 0, 0, 0);

        // Reset state while held low.
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 64'(obs()), 64'(14'h0000));
        check("reset_counts", {pkt_count0, pkt_count1}, 64'd0);

        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        foreach (tv[i]) begin
            @(negedge clk);
            drive(tv[i].en, tv[i].s0v, tv[i].s0d, tv[i].s1v, tv[i].s1d,
                  tv[i].rdy);
            #1;
            exp = {tv[i].g, tv[i].mv, tv[i].md, tv[i].s0r, tv[i].s1r,
                   tv[i].err};
            check($sformatf("row%0d", i), 64'(obs()), 64'(exp));
        end

        @(negedge clk);
        drive(2'b00, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        #1;
        check("count0_table", 64'(pkt_count0), 64'(STATS * 3));
        check("count1_table", 64'(pkt_count1), 64'(STATS * 3));

        // Reset mid-packet from s1.
        @(negedge clk);
        drive(2'b11, 1'b0, 8'h00, 1'b1, 8'h61, 1'b1);
        @(negedge clk);
        drive(2'b11, 1'b0, 8'h00, 1'b1, 8'h61, 1'b0);
        #1;
        check("pre_reset_grant", 64'(grant), 64'(2'b10));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_out", 64'(obs()), 64'(14'h0000));
        check("async_reset_cnt", {pkt_count0, pkt_count1}, 64'd0);
        @(negedge clk);
        drive(2'b11, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        for (int p = 0; p < 2; p++) begin
            @(negedge clk);
            drive(2'b11, 1'b0, 8'h00, 1'b1, 8'h61, 1'b1);
            #1;
            check("post_reset_idle", 64'(grant), 64'(2'b00));
            @(negedge clk);
            #1;
            check("post_reset_b0", 64'(obs()),
                  64'({2'b10, 1'b1, 8'h61, 1'b0, 1'b1, 1'b0}));
            @(negedge clk);
            drive(2'b11, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1);
            #1;
            check("post_reset_b1", 64'(obs()),
                  64'({2'b10, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0}));
            @(negedge clk);
            drive(2'b11, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        end
        @(negedge clk);
        #1;
        check("count1_after_rst", 64'(pkt_count1), 64'(STATS * 2));
        check("count0_after_rst", 64'(pkt_count0), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
